// File: rtl/hazard_stall_control_if.sv
// Pipeline hazard-control bundle: hazard/redirect requests in, stage enables,
// bubble/flush controls and performance counters out.
interface hazard_stall_control_if #(
  parameter int CNT_W = 16
);
  logic             stall_for_load;
  logic             flush_req;
  logic             pc_en;
  logic             if_id_en;
  logic             id_rr_en;
  logic             rr_ex_en;
  logic             ex_mem_bubble;
  logic             flush_if_id;
  logic             flush_id_rr;
  logic             flush_rr_ex;
  logic             pc_sel_target;
  logic             stall_active;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output stall_for_load, flush_req,
    input  pc_en, if_id_en, id_rr_en, rr_ex_en, ex_mem_bubble,
    input  flush_if_id, flush_id_rr, flush_rr_ex, pc_sel_target,
    input  stall_active, stall_cnt, flush_cnt
  );

  modport slave (
    input  stall_for_load, flush_req,
    output pc_en, if_id_en, id_rr_en, rr_ex_en, ex_mem_bubble,
    output flush_if_id, flush_id_rr, flush_rr_ex, pc_sel_target,
    output stall_active, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_stall_control.sv
// Load-use stall / EX-redirect flush sequencer (RUN -> LOAD_STALL -> GUARD).
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush counters.
module hazard_stall_control #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_stall_control_if.slave bus
);
  typedef enum logic [1:0] {RUN, LOAD_STALL, GUARD} state_t;

  localparam logic [1:0] REM_INIT = 2'(STALL_CYCLES - 1);

  state_t     state, nxt;
  logic [1:0] rem, rem_nxt;
  logic       freeze, flush_ok;
  logic       stall_active_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      rem            <= '0;
      stall_active_q <= 1'b0;
    end else begin
      state          <= nxt;
      rem            <= rem_nxt;
      stall_active_q <= (nxt == LOAD_STALL);
    end
  end

  always_comb begin
    nxt      = state;
    rem_nxt  = rem;
    freeze   = 1'b0;
    flush_ok = 1'b0;
    case (state)
      RUN: begin
        if (bus.stall_for_load) begin
          freeze = 1'b1;
          if (STALL_CYCLES == 1) begin
            nxt = GUARD;
          end else begin
            nxt     = LOAD_STALL;
            rem_nxt = REM_INIT;
          end
        end else if (bus.flush_req) begin
          flush_ok = 1'b1;
        end
      end
      LOAD_STALL: begin
        freeze  = 1'b1;
        rem_nxt = rem - 2'd1;
        if (rem <= 2'd1) nxt = GUARD;
      end
      GUARD: begin
        // load request masked here so one load yields exactly one episode
        flush_ok = bus.flush_req;
        nxt      = RUN;
      end
      default: nxt = RUN;
    endcase
  end

  // Reset forces the pipeline held and flushed without waiting for an edge
  always_comb begin
    if (!rst_n) begin
      bus.pc_en         = 1'b0;
      bus.if_id_en      = 1'b0;
      bus.id_rr_en      = 1'b0;
      bus.rr_ex_en      = 1'b0;
      bus.ex_mem_bubble = 1'b0;
      bus.flush_if_id   = 1'b1;
      bus.flush_id_rr   = 1'b1;
      bus.flush_rr_ex   = 1'b1;
      bus.pc_sel_target = 1'b0;
    end else begin
      bus.pc_en         = ~freeze;
      bus.if_id_en      = ~freeze;
      bus.id_rr_en      = ~freeze;
      bus.rr_ex_en      = ~freeze;
      bus.ex_mem_bubble = freeze;
      bus.flush_if_id   = flush_ok;
      bus.flush_id_rr   = flush_ok;
      bus.flush_rr_ex   = flush_ok;
      bus.pc_sel_target = flush_ok;
    end
  end

  assign bus.stall_active = stall_active_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (freeze && (stall_cnt_q != '1))   stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_ok && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif
endmodule
